modexp: RTL

MODEXP -- requirements
Module: modexp

---
 rtl/rsa_pkg.sv | 26 ++
 rtl/monpro.sv | 84 ++++++++
 rtl/modexp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular-exponentiation datapath.
package rsa_pkg;

    // Default operand width for modexp and monpro.
    localparam int RSA_DATAWIDTH = 64;

    // Bit-serial Montgomery multiplier control.
    typedef enum logic [1:0] {
        MP_IDLE = 2'd0,
        MP_RUN  = 2'd1,
        MP_FIN  = 2'd2
    } monpro_state_t;

    // Left-to-right square-and-multiply exponentiation control.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MBAR = 3'd1,
        XBAR = 3'd2,
        SQR  = 3'd3,
        MUL  = 3'd4,
        POST = 3'd5,
        FIX  = 3'd6,
        DONE = 3'd7
    } modexp_state_t;

endpackage

// File: rtl/monpro.sv
// Bit-serial Montgomery product U = A*B*2^-DATAWIDTH mod N (result < 2N).
// One multiplier bit per cycle, plus one capture cycle and one output cycle.
module monpro
    import rsa_pkg::*;
#(
    parameter int DATAWIDTH = RSA_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 ready,
    input  logic [DATAWIDTH-1:0] i_A,
    input  logic [DATAWIDTH-1:0] i_B,
    input  logic [DATAWIDTH-1:0] i_N,
    output logic                 o_valid,
    output logic [DATAWIDTH-1:0] o_U
);
    localparam int CW = $clog2(DATAWIDTH);

    monpro_state_t        state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
    // Two guard bits: the accumulator can reach u + B + N with B < 2N.
    logic [DATAWIDTH+1:0] u_q, u_d, t1, t2;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] u_sub;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= MP_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            u_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            u_q     <= u_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: add B if the current A bit is set, add N to make it even, halve.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        u_d     = u_q;
        cnt_d   = cnt_q;
        t1      = u_q + (a_q[0] ? {2'b00, b_q} : '0);
        t2      = t1 + (t1[0] ? {2'b00, n_q} : '0);
        case (state_q)
            MP_IDLE: begin
                if (start) begin
                    a_d     = i_A;
                    b_d     = i_B;
                    n_d     = i_N;
                    u_d     = '0;
                    cnt_d   = '0;
                    state_d = MP_RUN;
                end
            end
            MP_RUN: begin
                u_d   = t2 >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATAWIDTH - 1)) state_d = MP_FIN;
            end
            MP_FIN:  state_d = MP_IDLE;
            default: state_d = MP_IDLE;
        endcase
    end

    // One conditional subtraction keeps the product below 2N so it fits DATAWIDTH bits.
    assign u_sub   = u_q[DATAWIDTH-1:0] - n_q;
    assign o_U     = (u_q >= {2'b00, n_q}) ? u_sub : u_q[DATAWIDTH-1:0];
    assign o_valid = (state_q == MP_FIN);
    assign ready   = (state_q == MP_IDLE) && !start;

endmodule

// File: rtl/modexp.sv
// Modular exponentiation C = M^E mod N via Montgomery products, MSB-first
// over all DATAWIDTH exponent bits, with a final one-step reduction.
module modexp
    import rsa_pkg::*;
#(
    parameter int DATAWIDTH = RSA_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 ready,
    output logic                 o_valid,
    input  logic [DATAWIDTH-1:0] i_M,
    input  logic [DATAWIDTH-1:0] i_E,
    input  logic [DATAWIDTH-1:0] i_N,
    input  logic [DATAWIDTH-1:0] i_R2,
    output logic [DATAWIDTH-1:0] o_C
);
    localparam int KW = $clog2(DATAWIDTH);

    modexp_state_t        state_q, state_d;
    logic [DATAWIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d, r2_q, r2_d;
    logic [DATAWIDTH-1:0] mbar_q, mbar_d, xbar_q, xbar_d, c_q, c_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 mp_start_q, mp_start_d;
    logic                 mp_ready, mp_valid;
    logic [DATAWIDTH-1:0] mp_a, mp_b, mp_U;
    logic [DATAWIDTH:0]   diff;

    monpro #(.DATAWIDTH(DATAWIDTH)) u_monpro (
        .clk     (clk),
        .rstn    (rstn),
        .start   (mp_start_q),
        .ready   (mp_ready),
        .i_A     (mp_a),
        .i_B     (mp_b),
        .i_N     (n_q),
        .o_valid (mp_valid),
        .o_U     (mp_U)
    );

    // Control and operand registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            m_q        <= '0;
            e_q        <= '0;
            n_q        <= '0;
            r2_q       <= '0;
            mbar_q     <= '0;
            xbar_q     <= '0;
            c_q        <= '0;
            k_q        <= '0;
            mp_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            e_q        <= e_d;
            n_q        <= n_d;
            r2_q       <= r2_d;
            mbar_q     <= mbar_d;
            xbar_q     <= xbar_d;
            c_q        <= c_d;
            k_q        <= k_d;
            mp_start_q <= mp_start_d;
        end
    end

    // Multiplier operands follow the state; they are sampled on the monpro start cycle.
    always_comb begin
        mp_a = xbar_q;
        mp_b = xbar_q;
        case (state_q)
            MBAR: begin mp_a = m_q;              mp_b = r2_q;             end
            XBAR: begin mp_a = DATAWIDTH'(1);    mp_b = r2_q;             end
            MUL:  begin mp_a = mbar_q;           mp_b = xbar_q;           end
            POST: begin mp_a = xbar_q;           mp_b = DATAWIDTH'(1);    end
            default: ;
        endcase
    end

    // Sequencing: each product state launches one monpro run on entry and waits for valid.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        e_d        = e_q;
        n_d        = n_q;
        r2_d       = r2_q;
        mbar_d     = mbar_q;
        xbar_d     = xbar_q;
        c_d        = c_q;
        k_d        = k_q;
        mp_start_d = 1'b0;
        diff       = {1'b0, xbar_q} - {1'b0, n_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d        = i_M;
                    e_d        = i_E;
                    n_d        = i_N;
                    r2_d       = i_R2;
                    c_d        = '0;
                    mp_start_d = 1'b1;
                    state_d    = MBAR;
                end
            end
            MBAR: begin
                if (mp_valid) begin
                    mbar_d     = mp_U;
                    mp_start_d = 1'b1;
                    state_d    = XBAR;
                end
            end
            XBAR: begin
                if (mp_valid) begin
                    xbar_d     = mp_U;
                    k_d        = KW'(DATAWIDTH - 1);
                    mp_start_d = 1'b1;
                    state_d    = SQR;
                end
            end
            SQR, MUL: begin
                if (mp_valid) begin
                    xbar_d     = mp_U;
                    mp_start_d = 1'b1;
                    if (state_q == SQR && e_q[k_q]) begin
                        state_d = MUL;
                    end else if (k_q == '0) begin
                        state_d = POST;
                    end else begin
                        k_d     = k_q - KW'(1);
                        state_d = SQR;
                    end
                end
            end
            POST: begin
                if (mp_valid) begin
                    xbar_d  = mp_U;
                    state_d = FIX;
                end
            end
            FIX: begin
                // A borrow out of the top bit means X < N, so X is already reduced.
                c_d     = diff[DATAWIDTH] ? xbar_q : diff[DATAWIDTH-1:0];
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_C     = c_q;
    assign o_valid = (state_q == DONE);
    assign ready   = (state_q == IDLE) && !start;

endmodule
